// File: rtl/trivium_prng.sv
// trivium_prng: Trivium keystream generator serving 128-bit random blocks
// to gen_a over a pulsed request/valid handshake. A reseed pulse loads key
// and IV from the seed bus, runs the 1152-round warmup, then acks. Each
// rdi_ready pulse (or a latched pending request) produces one block.
module trivium_prng #(
    parameter int UNROLL = 64      // keystream bits per clock: 32 or 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] seed,
    input  logic         reseed,
    output logic         reseed_ack,
    input  logic         rdi_ready,
    output logic [127:0] rdi_data,
    output logic         rdi_valid
);

    localparam int WARM_CYC = 1152 / UNROLL;
    localparam int GEN_CYC  = 128 / UNROLL;
    localparam int CNT_W    = $clog2(WARM_CYC);

    typedef enum logic [1:0] {
        UNSEEDED,
        WARMUP,
        IDLE,
        GEN
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 pending;
    // st[i-1] holds Trivium bit s_i (s1..s288)
    logic [287:0]         st;
    logic [287:0]         st_next;
    logic [287:0]         st_load;
    logic [UNROLL-1:0]    zvec;
    logic [127:0]         staging;
    logic [127:0]         staging_next;

    // Seed bits above the 160-bit key/IV field carry no meaning here
    logic unused_seed_hi;
    assign unused_seed_hi = ^seed[255:160];

    // Initial state: key in s1..s80, IV in s94..s173, s286..s288 set
    always_comb begin
        st_load          = '0;
        st_load[79:0]    = seed[79:0];
        st_load[172:93]  = seed[159:80];
        st_load[287:285] = 3'b111;
    end

    // UNROLL Trivium rounds chained combinationally; zvec[j] is round j's z
    always_comb begin
        logic [287:0] sv;
        logic         t1, t2, t3;
        sv   = st;
        t1   = 1'b0;
        t2   = 1'b0;
        t3   = 1'b0;
        zvec = '0;
        for (int j = 0; j < UNROLL; j++) begin
            t1      = sv[65]  ^ sv[92];
            t2      = sv[161] ^ sv[176];
            t3      = sv[242] ^ sv[287];
            zvec[j] = t1 ^ t2 ^ t3;
            t1      = t1 ^ (sv[90]  & sv[91])  ^ sv[170];
            t2      = t2 ^ (sv[174] & sv[175]) ^ sv[263];
            t3      = t3 ^ (sv[285] & sv[286]) ^ sv[68];
            sv      = {sv[286:177], t2, sv[175:93], t1, sv[91:0], t3};
        end
        st_next = sv;
    end

    // Earlier keystream bits end up in the low bits of the block
    assign staging_next = {zvec, staging[127:UNROLL]};

    // Control FSM: reseed overrides every state; outputs are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= UNSEEDED;
            cnt        <= '0;
            pending    <= 1'b0;
            st         <= '0;
            staging    <= '0;
            rdi_data   <= '0;
            rdi_valid  <= 1'b0;
            reseed_ack <= 1'b0;
        end else begin
            reseed_ack <= 1'b0;
            rdi_valid  <= 1'b0;
            if (reseed) begin
                // A request arriving with the reseed is kept and served after ack
                st      <= st_load;
                cnt     <= '0;
                state   <= WARMUP;
                pending <= pending | rdi_ready;
            end else begin
                case (state)
                    UNSEEDED: begin
                        if (rdi_ready) pending <= 1'b1;
                    end
                    WARMUP: begin
                        st <= st_next;
                        if (rdi_ready) pending <= 1'b1;
                        if (cnt == CNT_W'(WARM_CYC - 1)) begin
                            cnt        <= '0;
                            state      <= IDLE;
                            reseed_ack <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    IDLE: begin
                        // During the valid cycle a fresh ready is only latched;
                        // a ready seen while already pending is dropped
                        if (pending || (rdi_ready && !rdi_valid)) begin
                            state   <= GEN;
                            cnt     <= '0;
                            pending <= 1'b0;
                        end else if (rdi_ready) begin
                            pending <= 1'b1;
                        end
                    end
                    GEN: begin
                        st      <= st_next;
                        staging <= staging_next;
                        if (rdi_ready) pending <= 1'b1;
                        if (cnt == CNT_W'(GEN_CYC - 1)) begin
                            cnt       <= '0;
                            rdi_data  <= staging_next;
                            rdi_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= UNSEEDED;
                endcase
            end
        end
    end

endmodule
